// File: rtl/rv_core_pkg.sv
// Shared core-wide constants and types used by the fetch stage, the decoder and their benches.
package rv_core_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv_fetch_fifo.sv
// Instruction buffer between fetch and decode: {pc, instr} entries, flushable.
module rv_fetch_fifo
  import rv_core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q < CW'(DEPTH)) || do_pop);

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/rv_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited word fetches, buffers responses for decode.
module rv_fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            resetn,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occupancy;
  logic            req_fire, rsp_take, rsp_keep, pop;
  fetch_entry_t    head, push_entry;

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;

  // A slot freed by this cycle's pop can be re-credited: its replacement arrives no earlier than next cycle.
  assign occupancy      = {1'b0, inflight_q} + {1'b0, fifo_count} - (CW+1)'(pop);
  assign imem_req_valid = resetn && !redirect_valid && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_take   = imem_rsp_valid && (inflight_q != '0);
  assign rsp_keep   = rsp_take && (drop_q == '0) && !redirect_valid;
  assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_take);
    drop_d     = drop_q;
    if (redirect_valid) begin
      fetch_pc_d = align_word(redirect_pc);
      rsp_pc_d   = align_word(redirect_pc);
      // Everything still owed belongs to the abandoned stream; already-dropped slots are part of inflight.
      drop_d     = inflight_q - CW'(rsp_take);
    end else begin
      if (req_fire)                   fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_take && drop_q != '0)   drop_d     = drop_q - CW'(1);
      if (rsp_keep)                   rsp_pc_d   = rsp_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  rv_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (fifo_count)
  );

  assign out_instr = head.instr;
  assign out_pc    = head.pc;

  always @(posedge clk) begin
    if (resetn) begin
      assert (!(imem_rsp_valid && inflight_q == '0))
        else $error("rv_fetch_unit: imem response with no request in flight");
    end
  end

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Scoreboard bench for rv_fetch_unit: latency-programmable memory model plus decode-side monitor.
module tb_rv_fetch_unit;
  import rv_core_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk, resetn;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc;

  rv_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int pops = 0;
  int acc_cnt = 0;
  int first_acc_cyc = 0;
  int first_pop_cyc = 0;
  int mem_lat = 1;
  fetch_entry_t exp_q[$];
  logic [31:0]  acc_addrs[$];

  typedef struct { int due; logic [31:0] addr; } mem_req_t;
  mem_req_t mq[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:12] == 20'hFFFFF) return NOP_INSTR;
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic push_exp(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] pc;
      pc = start + 32'(4 * i);
      exp_q.push_back('{pc: pc, instr: mem_word(pc)});
    end
  endtask

  task automatic wait_pops(input int target, input int budget);
    int n;
    n = 0;
    while (pops < target && n < budget) begin
      @(negedge clk); #3;
      n++;
    end
    check("pop_budget", 32'(pops >= target), 32'd1);
  endtask

  task automatic do_reset(input int lat);
    @(negedge clk);
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    resetn         = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    acc_addrs.delete();
    pops           = 0;
    acc_cnt        = 0;
    mem_lat        = lat;
    imem_req_ready = 1'b1;
  endtask

  // Memory: drive due response at negedge, sample the handshake that completes at the next posedge.
  initial begin
    mem_req_t r;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        r = mq.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(r.addr);
      end
      #2;
      if (!resetn) begin
        mq.delete();
        imem_rsp_valid = 1'b0;
      end else if (imem_req_valid && imem_req_ready) begin
        if (acc_cnt == 0) first_acc_cyc = cyc;
        acc_cnt++;
        acc_addrs.push_back(imem_req_addr);
        mq.push_back('{due: cyc + mem_lat, addr: imem_req_addr});
      end
    end
  end

  // Decode-side monitor: every consumed instruction is compared with the scoreboard head.
  initial begin
    fetch_entry_t e;
    forever begin
      @(negedge clk); #2;
      if (resetn && out_valid && out_ready) begin
        pops++;
        if (pops == 1) first_pop_cyc = cyc;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL out_unexpected: got pc %h instr %h, expected nothing", out_pc, out_instr);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", out_pc, e.pc);
          check("out_instr", out_instr, e.instr);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    logic [31:0] held;
    resetn         = 1'b0;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;

    // Reset values
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);

    // Streaming from reset, 1-cycle memory
    repeat (2) @(negedge clk);
    push_exp(RESET_PC, 40);
    out_ready = 1'b1;
    resetn    = 1'b1;
    wait_pops(1, 20);
    check("first_out_latency", 32'(first_pop_cyc - first_acc_cyc), 32'd2);
    repeat (7) @(negedge clk);
    #3;
    check("back_to_back_pops", 32'(pops), 32'd8);

    // Decoder stall from reset: buffer fills, requests stop
    do_reset(1);
    push_exp(RESET_PC, 40);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    #3;
    check("stall_accepts", 32'(acc_cnt), 32'(DEPTH));
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    wait_pops(12, 40);

    // Memory back-pressure: address held, stream resumes in order
    @(negedge clk);
    imem_req_ready = 1'b0;
    #3;
    held = imem_req_addr;
    repeat (5) begin
      @(negedge clk); #3;
      check("addr_hold", imem_req_addr, held);
    end
    check("blocked_req_valid", 32'(imem_req_valid), 32'd1);
    @(negedge clk);
    imem_req_ready = 1'b1;
    base = pops;
    wait_pops(base + 6, 40);

    // Redirect to 0x100 with two fetches in flight on a 3-cycle memory
    do_reset(3);
    resetn = 1'b1;
    n = 0;
    while (acc_cnt < 2 && n < 10) begin
      @(negedge clk); #3;
      n++;
    end
    check("two_inflight", 32'(acc_cnt), 32'd2);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    #3;
    exp_q.delete();
    push_exp(32'h0000_0100, 40);
    out_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_pops(4, 60);

    // Redirect to 0x203 in a cycle that carries a response
    repeat (4) @(negedge clk);
    n = 0;
    while (n < 20) begin
      @(negedge clk); #1;
      if (imem_rsp_valid) break;
      n++;
    end
    check("rsp_coincident", 32'(imem_rsp_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    #2;
    exp_q.delete();
    acc_addrs.delete();
    push_exp(32'h0000_0200, 40);
    @(negedge clk);
    redirect_valid = 1'b0;
    base = pops;
    wait_pops(base + 4, 60);
    check("restart_addr", acc_addrs[0], 32'h0000_0200);

    // Address wrap through 0xFFFF_FFFC
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    #1;
    check("redirect_no_req", 32'(imem_req_valid), 32'd0);
    #2;
    exp_q.delete();
    acc_addrs.delete();
    push_exp(32'hFFFF_FFF8, 40);
    @(negedge clk);
    redirect_valid = 1'b0;
    base = pops;
    wait_pops(base + 5, 60);
    check("wrap_acc_count", 32'(acc_addrs.size() >= 3), 32'd1);
    check("wrap_acc_last", acc_addrs[1], 32'hFFFF_FFFC);
    check("wrap_acc_zero", acc_addrs[2], 32'h0000_0000);

    // Reset asserted mid-stream, then refetch from RESET_PC
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    check("midrst_req_addr", imem_req_addr, RESET_PC);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_instr", out_instr, 32'd0);
    check("midrst_out_pc", out_pc, 32'd0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    push_exp(RESET_PC, 40);
    mem_lat = 1;
    pops    = 0;
    resetn  = 1'b1;
    wait_pops(6, 40);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
